// File: rtl/rx_controller_pkg.sv
// Shared UART definitions: the frame FSM state encoding used by both transmitter and receiver,
// plus the default bit period for a 50 MHz clock at 9600 baud.
package rx_controller_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_e;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 5208;

  // Counter value at which the start bit is re-checked, half a bit after the falling edge.
  function automatic logic [15:0] mid_count(input int unsigned clks_per_bit);
    return 16'((clks_per_bit - 1) / 2);
  endfunction

endpackage

// File: rtl/rx_controller_if.sv
// Byte delivery bus between the UART receiver (master) and the CPU-side register block (slave).
interface rx_controller_if;
  logic       RX_ACK;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_DONE;
  logic       RX_FERR;
  logic       RX_OVR;
  logic       RX_BUSY;

  modport master (
    input  RX_ACK,
    output RX_DATA, RX_VALID, RX_DONE, RX_FERR, RX_OVR, RX_BUSY
  );

  modport slave (
    output RX_ACK,
    input  RX_DATA, RX_VALID, RX_DONE, RX_FERR, RX_OVR, RX_BUSY
  );
endinterface

// File: rtl/rx_controller_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; RST_VAL sets the value read out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/rx_controller.sv
// 8N1 UART receiver: mid-bit sampling of a synchronized RXD, byte held until acknowledged.
//   state   | meaning
//   IDLE    | line idle, waiting for a falling start edge
//   START   | half-bit wait, then confirm the start bit is still low
//   DATA    | sample 8 data bits LSB first, one per bit period
//   STOP    | sample stop bit; load byte or flag framing error
//   CLEANUP | end pulses, wait for the line to return high
module rx_controller
  import rx_controller_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             UART_RXD,
  rx_controller_if.master  bus
);

  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CNT_MID  = mid_count(CLKS_PER_BIT);

  logic        rxd_s;
  uart_state_e state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        done_q;
  logic        ferr_q;
  logic        ovr_q;
  logic        busy_q;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_rxd (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (UART_RXD),
    .q_o   (rxd_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (bus.RX_ACK) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          idx_q  <= '0;
          busy_q <= 1'b0;
          if (!rxd_s) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (cnt_q == CNT_MID) begin
            cnt_q <= '0;
            if (!rxd_s) begin
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rxd_s;
            if (idx_q == 3'd7) begin
              idx_q   <= '0;
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= CLEANUP;
            if (rxd_s) begin
              data_q  <= shift_q;
              done_q  <= 1'b1;
              valid_q <= 1'b1;
              // A load wins over a simultaneous ack: the flag neither sets nor clears.
              if (bus.RX_ACK) begin
                ovr_q <= ovr_q;
              end else if (valid_q) begin
                ovr_q <= 1'b1;
              end
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        CLEANUP: begin
          done_q <= 1'b0;
          ferr_q <= 1'b0;
          if (rxd_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RX_DATA  = data_q;
  assign bus.RX_VALID = valid_q;
  assign bus.RX_DONE  = done_q;
  assign bus.RX_FERR  = ferr_q;
  assign bus.RX_OVR   = ovr_q;
  assign bus.RX_BUSY  = busy_q;

endmodule
